// File: rtl/product_enc_pkg.sv
// Shared widths, cycle counts and FSM encoding for the product encoder.
package product_enc_pkg;

  localparam int FACT_W   = 4;
  localparam int MUL1_W   = 8;
  localparam int PROD_W   = 12;
  localparam int BCD_W    = 24;
  localparam int MUL_CYC  = 4;
  localparam int CONV_CYC = 12;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    MUL2 = 3'd2,
    CONV = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/product_enc_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per enabled cycle, 12-bit binary to 6 BCD digits.
module bin2bcd_seq
  import product_enc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [PROD_W-1:0] i_bin,
  output logic [BCD_W-1:0]  o_bcd
);

  logic [PROD_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_adj;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_adj = add3(r_bcd);

  // Load folds in the first step: with all digits zero the add-3 is a no-op,
  // so the MSB can be shifted straight in and 11 enabled steps remain.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
    end else if (i_load) begin
      r_bcd <= {{(BCD_W-1){1'b0}}, i_bin[PROD_W-1]};
      r_bin <= {i_bin[PROD_W-2:0], 1'b0};
    end else if (i_shift) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[PROD_W-1]};
      r_bin <= {r_bin[PROD_W-2:0], 1'b0};
    end
  end

  assign o_bcd = r_bcd;

endmodule

// File: rtl/product_enc.sv
// Multiplies three 4-bit factors by shift-add, converts to BCD, and reports the result with a DONE pulse.
module product_enc
  import product_enc_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [FACT_W-1:0] FACT1,
  input  logic [FACT_W-1:0] FACT2,
  input  logic [FACT_W-1:0] FACT3,
  output logic [BCD_W-1:0]  QUESTION,
  output logic [PROD_W-1:0] PRODUCT,
  output logic              BUSY,
  output logic              DONE,
  output logic              INVALID
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [FACT_W-1:0]   r_f1, r_f2, r_f3;
  logic [MUL1_W-1:0]   r_acc1;
  logic [PROD_W-1:0]   r_acc2;
  logic [PROD_W-1:0]   w_acc2_nxt;
  logic [PROD_W-1:0]   r_product;
  logic [BCD_W-1:0]    r_question;
  logic                r_invalid;
  logic                w_mul_last;
  logic                w_conv_last;
  logic                w_load;
  logic                w_shift;
  logic [BCD_W-1:0]    w_bcd;

  assign w_mul_last  = (r_cnt == CNT_W'(MUL_CYC - 1));
  assign w_conv_last = (r_cnt == CNT_W'(CONV_CYC - 1));
  assign w_acc2_nxt  = r_acc2 + (r_f3[r_cnt[1:0]] ? (PROD_W'(r_acc1) << r_cnt[1:0]) : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: if (START) w_state_nxt = MUL1;
      MUL1: if (w_mul_last) w_state_nxt = MUL2;
      MUL2: begin
        if (w_mul_last) begin
          w_state_nxt = CONV;
          w_load      = 1'b1;
        end
      end
      CONV: begin
        w_shift = !w_conv_last;
        if (w_conv_last) w_state_nxt = FIN;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt      <= '0;
      r_f1       <= '0;
      r_f2       <= '0;
      r_f3       <= '0;
      r_acc1     <= '0;
      r_acc2     <= '0;
      r_product  <= '0;
      r_question <= '0;
      r_invalid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            r_f1   <= FACT1;
            r_f2   <= FACT2;
            r_f3   <= FACT3;
            r_acc1 <= '0;
            r_acc2 <= '0;
            r_cnt  <= '0;
          end
        end
        MUL1: begin
          if (r_f2[r_cnt[1:0]]) r_acc1 <= r_acc1 + (MUL1_W'(r_f1) << r_cnt[1:0]);
          r_cnt <= w_mul_last ? '0 : r_cnt + 1'b1;
        end
        MUL2: begin
          r_acc2 <= w_acc2_nxt;
          r_cnt  <= w_mul_last ? '0 : r_cnt + 1'b1;
        end
        CONV: begin
          r_cnt <= w_conv_last ? '0 : r_cnt + 1'b1;
          // Results become visible only on entry to FIN.
          if (w_conv_last) begin
            r_product  <= r_acc2;
            r_question <= w_bcd;
            r_invalid  <= (r_f1 < 4'd2) || (r_f2 < 4'd2) || (r_f3 < 4'd2);
          end
        end
        default: ;
      endcase
    end
  end

  bin2bcd_seq u_bcd (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_bin   (w_acc2_nxt),
    .o_bcd   (w_bcd)
  );

  assign QUESTION = r_question;
  assign PRODUCT  = r_product;
  assign INVALID  = r_invalid;
  assign BUSY     = (r_state != IDLE);
  assign DONE     = (r_state == FIN);

endmodule

// File: tb/tb_product_enc.sv
// Directed, table-driven bench for product_enc plus sequences for ignored START, reset abort and back-to-back runs.
module tb_product_enc;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [3:0]  FACT1 = '0, FACT2 = '0, FACT3 = '0;
  logic [23:0] QUESTION;
  logic [11:0] PRODUCT;
  logic        BUSY, DONE, INVALID;

  int n_checks = 0;
  int n_errors = 0;

  product_enc dut (
    .CLK(CLK), .RST(RST), .START(START),
    .FACT1(FACT1), .FACT2(FACT2), .FACT3(FACT3),
    .QUESTION(QUESTION), .PRODUCT(PRODUCT),
    .BUSY(BUSY), .DONE(DONE), .INVALID(INVALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  f1, f2, f3;
    logic [11:0] prod;
    logic [23:0] q;
    logic        inv;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one START pulse, then watches 30 cycles; cycle 1 is the one after START was sampled.
  task automatic run_encode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            output int lat, output int ndone, output logic [11:0] p,
                            output logic [23:0] q, output logic inv, output bit early);
    logic [11:0] p0;
    logic [23:0] q0;
    FACT1 = a; FACT2 = b; FACT3 = c;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    p0 = PRODUCT; q0 = QUESTION;
    lat = -1; ndone = 0; p = '0; q = '0; inv = 1'b0; early = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (DONE) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc; p = PRODUCT; q = QUESTION; inv = INVALID;
        end
      end else if (lat < 0 && (PRODUCT !== p0 || QUESTION !== q0)) begin
        early = 1'b1;
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    int lat, nd, first;
    logic [11:0] p;
    logic [23:0] q;
    logic inv;
    bit early;
    int d[3];
    int low[4];

    vecs[0] = '{4'd3,  4'd5,  4'd7,  12'd105,  24'h000105, 1'b0};
    vecs[1] = '{4'd15, 4'd15, 4'd15, 12'd3375, 24'h003375, 1'b0};
    vecs[2] = '{4'd0,  4'd7,  4'd11, 12'd0,    24'h000000, 1'b1};
    vecs[3] = '{4'd1,  4'd2,  4'd3,  12'd6,    24'h000006, 1'b1};
    vecs[4] = '{4'd2,  4'd2,  4'd2,  12'd8,    24'h000008, 1'b0};
    vecs[5] = '{4'd13, 4'd11, 4'd7,  12'd1001, 24'h001001, 1'b0};
    vecs[6] = '{4'd9,  4'd9,  4'd9,  12'd729,  24'h000729, 1'b0};
    vecs[7] = '{4'd14, 4'd1,  4'd5,  12'd70,   24'h000070, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    check("reset_question", QUESTION, 0);
    check("reset_product",  PRODUCT,  0);
    check("reset_busy",     BUSY,     0);
    check("reset_done",     DONE,     0);
    check("reset_invalid",  INVALID,  0);
    RST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 8; i++) begin
      run_encode(vecs[i].f1, vecs[i].f2, vecs[i].f3, lat, nd, p, q, inv, early);
      check($sformatf("v%0d_latency", i),   lat,       21);
      check($sformatf("v%0d_ndone", i),     nd,        1);
      check($sformatf("v%0d_product", i),   p,         vecs[i].prod);
      check($sformatf("v%0d_question", i),  q,         vecs[i].q);
      check($sformatf("v%0d_q_hi_zero", i), q[23:16],  0);
      check($sformatf("v%0d_invalid", i),   inv,       vecs[i].inv);
      check($sformatf("v%0d_no_early", i),  early,     0);
      check($sformatf("v%0d_hold", i),      PRODUCT,   vecs[i].prod);
      check($sformatf("v%0d_idle", i),      BUSY,      0);
    end

    // START and new factors mid-encode must be ignored, not queued.
    FACT1 = 4'd2; FACT2 = 4'd3; FACT3 = 4'd5;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    nd = 0; first = -1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (cyc == 5) begin
        START = 1'b1; FACT1 = 4'd7; FACT2 = 4'd7; FACT3 = 4'd7;
      end
      if (cyc == 6) START = 1'b0;
      if (DONE) begin
        nd++;
        if (first < 0) begin
          first = cyc;
          check("ign_product", PRODUCT, 30);
          check("ign_question", QUESTION, 24'h000030);
        end
      end
      @(posedge CLK); #1;
    end
    check("ign_latency", first, 21);
    check("ign_ndone", nd, 1);

    // Reset at cycle 10 aborts; START with the first RST=1 edge is honoured.
    FACT1 = 4'd3; FACT2 = 4'd5; FACT3 = 4'd7;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    nd = 0; first = -1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (DONE) begin
        nd++;
        if (first < 0) first = cyc;
      end
      if (cyc == 10) RST = 1'b0;
      if (cyc == 11) begin
        check("rst_question", QUESTION, 0);
        check("rst_product",  PRODUCT,  0);
        check("rst_busy",     BUSY,     0);
        check("rst_done",     DONE,     0);
        check("rst_invalid",  INVALID,  0);
        RST = 1'b1; START = 1'b1;
        FACT1 = 4'd4; FACT2 = 4'd5; FACT3 = 4'd6;
      end
      if (cyc == 12) START = 1'b0;
      @(posedge CLK); #1;
    end
    check("rst_first_done", first, 32);
    check("rst_ndone", nd, 1);
    check("rst_product_after", PRODUCT, 120);
    check("rst_question_after", QUESTION, 24'h000120);

    // START held high: back-to-back runs 22 cycles apart with one idle cycle between.
    FACT1 = 4'd3; FACT2 = 4'd5; FACT3 = 4'd7;
    START = 1'b1;
    @(posedge CLK); #1;
    nd = 0;
    d = '{-1, -1, -1};
    low = '{0, 0, 0, 0};
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (DONE && nd < 3) begin
        d[nd] = cyc;
        nd++;
      end
      if (!BUSY) low[nd]++;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    check("b2b_first", d[0], 21);
    check("b2b_gap1", d[1] - d[0], 22);
    check("b2b_gap2", d[2] - d[1], 22);
    check("b2b_low0", low[0], 0);
    check("b2b_low1", low[1], 1);
    check("b2b_low2", low[2], 1);
    check("b2b_product", PRODUCT, 105);
    repeat (30) @(posedge CLK);
    #1;
    check("b2b_drain_busy", BUSY, 0);
    check("b2b_drain_done", DONE, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
